// File: rtl/accel_host_port.sv
// Host-side initiator for the accelerator register port: a command FIFO feeding
// a small issue FSM that drives the peripheral pins, plus a one-entry read response register.
module accel_host_port #(
  parameter int FIFO_DEPTH = 4,
  parameter int READ_WAIT  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [3:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_addr,
  output logic [7:0] rsp_data,
  output logic [3:0] bus_address,
  output logic       bus_data_write,
  output logic [7:0] bus_data_in,
  input  logic [7:0] bus_data_out,
  output logic       busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = FIFO_DEPTH[AW:0];
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [3:0]    WAIT_INIT = READ_WAIT[3:0];

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;

  typedef struct packed {
    logic       write;
    logic [3:0] addr;
    logic [7:0] data;
  } cmd_t;

  cmd_t          fifo_mem [FIFO_DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic          ready_q;
  logic [1:0]    state;
  logic [3:0]    wait_cnt;
  logic          push, pop, empty, can_issue, rd_done;

  assign head      = fifo_mem[rd_ptr];
  assign empty     = (count == '0);
  assign push      = cmd_valid && ready_q;
  assign can_issue = (state == S_IDLE) || (state == S_WR);
  // A read may only leave the FIFO once the response register is free (or being freed).
  assign pop       = !empty && can_issue && (head.write || !rsp_valid || rsp_ready);
  assign rd_done   = (state == S_RD) && (wait_cnt == 4'd1);

  assign cmd_ready = ready_q;
  assign busy      = !empty || (state != S_IDLE) || rsp_valid;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{write: cmd_write, addr: cmd_addr, data: cmd_data};
  end

  // cmd_ready is registered from the next count so it is 0 during reset and never combinational.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count   <= count_next;
      ready_q <= (count_next != CNT_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      wait_cnt       <= '0;
      bus_address    <= '0;
      bus_data_in    <= '0;
      bus_data_write <= 1'b0;
    end else if (pop) begin
      bus_address    <= head.addr;
      bus_data_in    <= head.data;
      bus_data_write <= head.write;
      state          <= head.write ? S_WR : S_RD;
      wait_cnt       <= WAIT_INIT;
    end else if (state == S_WR) begin
      state          <= S_IDLE;
      bus_data_write <= 1'b0;
    end else if (rd_done) begin
      state          <= S_IDLE;
    end else if (state == S_RD) begin
      wait_cnt       <= wait_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_data  <= '0;
    end else if (rd_done) begin
      rsp_valid <= 1'b1;
      rsp_addr  <= bus_address;
      rsp_data  <= bus_data_out;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_accel_host_port.sv
// Bench for accel_host_port: directed latency/backpressure/reset cases plus random traffic,
// all bus activity and responses checked in order against an accepted-command queue.
module tb_accel_host_port;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0, rst3_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [3:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;
  logic       rsp_ready = 1'b0, rsp_ready3 = 1'b0;

  logic       cmd_ready, rsp_valid, bus_data_write, busy;
  logic [3:0] rsp_addr, bus_address;
  logic [7:0] rsp_data, bus_data_in, bus_data_out;
  logic       cmd_ready3, rsp_valid3, bus_data_write3, busy3;
  logic [3:0] rsp_addr3, bus_address3;
  logic [7:0] rsp_data3, bus_data_in3, bus_data_out3;

  logic [7:0] mem [16];
  assign bus_data_out  = mem[bus_address];
  assign bus_data_out3 = mem[bus_address3];

  always #5 clk = ~clk;

  accel_host_port #(.FIFO_DEPTH(4), .READ_WAIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .bus_address(bus_address), .bus_data_write(bus_data_write), .bus_data_in(bus_data_in),
    .bus_data_out(bus_data_out), .busy(busy));

  accel_host_port #(.FIFO_DEPTH(4), .READ_WAIT(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready3),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_addr(rsp_addr3), .rsp_data(rsp_data3),
    .bus_address(bus_address3), .bus_data_write(bus_data_write3), .bus_data_in(bus_data_in3),
    .bus_data_out(bus_data_out3), .busy(busy3));

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic w, input logic [3:0] a, input logic [7:0] d);
    int t = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_data = d;
    while (!cmd_ready && t < 50) begin step; t++; end
    chk("send_timeout", 32'(t < 50), 32'd1);
    step;
    cmd_valid = 1'b0;
  endtask

  // Scoreboard: every accepted command must show up, in acceptance order, either
  // as one bus write cycle or as one freshly loaded read response.
  typedef struct packed {logic w; logic [3:0] a; logic [7:0] d;} tcmd_t;
  tcmd_t exp_q[$];
  logic  v_prev = 1'b0, r_prev = 1'b0;

  always @(posedge clk) begin
    if (rst_n) begin
      if (rsp_valid && (!v_prev || r_prev)) begin
        if (exp_q.size() == 0) chk("sb_rsp_extra", 32'd1, 32'd0);
        else begin
          chk("sb_rsp_kind", 32'(exp_q[0].w), 32'd0);
          chk("sb_rsp_addr", 32'(rsp_addr), 32'(exp_q[0].a));
          chk("sb_rsp_data", 32'(rsp_data), 32'(mem[exp_q[0].a]));
          void'(exp_q.pop_front());
        end
      end
      if (bus_data_write) begin
        if (exp_q.size() == 0) chk("sb_wr_extra", 32'd1, 32'd0);
        else begin
          chk("sb_wr_kind", 32'(exp_q[0].w), 32'd1);
          chk("sb_wr_addr", 32'(bus_address), 32'(exp_q[0].a));
          chk("sb_wr_data", 32'(bus_data_in), 32'(exp_q[0].d));
          void'(exp_q.pop_front());
        end
      end
      if (cmd_valid && cmd_ready) exp_q.push_back({cmd_write, cmd_addr, cmd_data});
    end
    v_prev <= rsp_valid;
    r_prev <= rsp_ready;
  end

  task automatic drain(input string tag);
    int t = 0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    while (busy && t < 200) begin step; t++; end
    chk(tag, 32'(busy), 32'd0);
    step;
    rsp_ready = 1'b0;
  endtask

  initial begin
    int accepted;
    int t;
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    mem[7] = 8'h5C; mem[1] = 8'h11; mem[2] = 8'h22;

    // reset
    step; step;
    chk("rst_ready_low", 32'(cmd_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dw", 32'(bus_data_write), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1; rst3_n = 1'b1;
    step;
    chk("rst_ready_after", 32'(cmd_ready), 32'd1);

    // single write
    send(1'b1, 4'h3, 8'hA5);
    chk("wr1_c1_dw", 32'(bus_data_write), 32'd0);
    step;
    chk("wr1_c2_dw", 32'(bus_data_write), 32'd1);
    chk("wr1_c2_addr", 32'(bus_address), 32'h3);
    chk("wr1_c2_data", 32'(bus_data_in), 32'hA5);
    step;
    chk("wr1_c3_dw", 32'(bus_data_write), 32'd0);
    chk("wr1_rsp", 32'(rsp_valid), 32'd0);
    chk("wr1_busy", 32'(busy), 32'd0);

    // back-to-back writes
    for (int k = 0; k < 8; k++) begin
      if (k < 4) begin
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'(k); cmd_data = 8'(16 + k);
        chk("b2b_ready", 32'(cmd_ready), 32'd1);
      end else cmd_valid = 1'b0;
      if (k >= 2 && k <= 5) begin
        chk("b2b_dw", 32'(bus_data_write), 32'd1);
        chk("b2b_addr", 32'(bus_address), 32'(k - 2));
        chk("b2b_data", 32'(bus_data_in), 32'(14 + k));
      end else chk("b2b_dw_idle", 32'(bus_data_write), 32'd0);
      step;
    end

    // read latency, READ_WAIT=1 on dut and 3 on dut3
    send(1'b0, 4'h7, 8'h00);
    chk("rd_c1_valid", 32'(rsp_valid), 32'd0);
    step;
    chk("rd_c2_addr", 32'(bus_address), 32'h7);
    chk("rd_c2_valid", 32'(rsp_valid), 32'd0);
    chk("rd_c2_dw", 32'(bus_data_write), 32'd0);
    step;
    chk("rd_c3_valid", 32'(rsp_valid), 32'd1);
    chk("rd_c3_data", 32'(rsp_data), 32'h5C);
    chk("rd_c3_addr", 32'(rsp_addr), 32'h7);
    chk("rd3_c3_valid", 32'(rsp_valid3), 32'd0);
    rsp_ready = 1'b1;
    step;
    rsp_ready = 1'b0;
    chk("rd_c4_valid", 32'(rsp_valid), 32'd0);
    chk("rd3_c4_valid", 32'(rsp_valid3), 32'd0);
    step;
    chk("rd3_c5_valid", 32'(rsp_valid3), 32'd1);
    chk("rd3_c5_data", 32'(rsp_data3), 32'h5C);
    chk("rd3_c5_addr", 32'(rsp_addr3), 32'h7);
    rst3_n = 1'b0;

    // response backpressure
    send(1'b0, 4'h1, 8'h00);
    send(1'b0, 4'h2, 8'h00);
    send(1'b1, 4'h5, 8'h77);
    for (int k = 0; k < 4; k++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", 32'(rsp_data), 32'h11);
      chk("bp_addr", 32'(rsp_addr), 32'h1);
      chk("bp_bus_addr", 32'(bus_address), 32'h1);
      chk("bp_dw", 32'(bus_data_write), 32'd0);
      step;
    end
    rsp_ready = 1'b1;
    step;
    rsp_ready = 1'b0;
    chk("bp_rel_valid", 32'(rsp_valid), 32'd0);
    chk("bp_rel_bus_addr", 32'(bus_address), 32'h2);
    step;
    chk("bp_rsp2_valid", 32'(rsp_valid), 32'd1);
    chk("bp_rsp2_data", 32'(rsp_data), 32'h22);
    chk("bp_rsp2_addr", 32'(rsp_addr), 32'h2);
    chk("bp_wr_wait", 32'(bus_data_write), 32'd0);
    step;
    chk("bp_wr_dw", 32'(bus_data_write), 32'd1);
    chk("bp_wr_addr", 32'(bus_address), 32'h5);
    chk("bp_wr_data", 32'(bus_data_in), 32'h77);
    drain("bp_drain");

    // full FIFO behind a pending response
    send(1'b0, 4'h7, 8'h00);
    step; step;
    chk("full_pending", 32'(rsp_valid), 32'd1);
    accepted = 0;
    for (int k = 0; k < 20; k++) begin
      if (!cmd_ready) break;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'($urandom);
      accepted++;
      step;
    end
    cmd_valid = 1'b0;
    chk("full_count", 32'(accepted), 32'd4);
    chk("full_ready_low", 32'(cmd_ready), 32'd0);
    rsp_ready = 1'b1;
    step;
    rsp_ready = 1'b0;
    chk("full_ready_after", 32'(cmd_ready), 32'd1);
    drain("full_drain");

    // reset in the middle of a write burst
    send(1'b0, 4'h7, 8'h00);
    step; step;
    send(1'b0, 4'h1, 8'h00);
    send(1'b1, 4'h8, 8'hA1);
    send(1'b1, 4'h9, 8'hA2);
    send(1'b1, 4'hA, 8'hA3);
    rsp_ready = 1'b1;
    step;
    rsp_ready = 1'b0;
    send(1'b1, 4'hB, 8'hA4);
    t = 0;
    while (!bus_data_write && t < 30) begin step; t++; end
    chk("mrst_burst_seen", 32'(bus_data_write), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mrst_dw", 32'(bus_data_write), 32'd0);
    chk("mrst_addr", 32'(bus_address), 32'd0);
    chk("mrst_din", 32'(bus_data_in), 32'd0);
    chk("mrst_ready", 32'(cmd_ready), 32'd0);
    chk("mrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mrst_rsp_data", 32'(rsp_data), 32'd0);
    chk("mrst_rsp_addr", 32'(rsp_addr), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    step;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step;
      chk("mrst_post_busy", 32'(busy), 32'd0);
      chk("mrst_post_dw", 32'(bus_data_write), 32'd0);
    end

    // random traffic
    for (int k = 0; k < 600; k++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = 4'($urandom);
      cmd_data  = 8'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      step;
    end
    drain("rand_drain");
    chk("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
